// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared types and constants for the branch resolve block
// Purpose : FSM state enum, opcode/FUNCT3 constants and the next-PC select enum
//           used by branch_resolve and branch_decide.
// Ports   : none (package)
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    PC_SEL_PC4    = 2'b00,
    PC_SEL_JALR   = 2'b01,
    PC_SEL_BRANCH = 2'b10,
    PC_SEL_JAL    = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/branch_decide.sv
// rtl/branch_decide.sv - combinational taken / next-PC source / illegal decode
// Purpose : decides redirect and next-PC source from opcode, FUNCT3 and the
//           RS1-vs-RS2 comparison flags.
// Ports   : opcode_i, funct3_i, br_eq_i, br_lt_i, br_ltu_i (inputs)
//           taken_o, pc_sel_o, illegal_o (outputs)
module branch_decide
  import branch_resolve_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o,
  output pc_sel_e    pc_sel_o,
  output logic       illegal_o
);

  logic cond;

  always_comb begin
    cond      = 1'b0;
    taken_o   = 1'b0;
    pc_sel_o  = PC_SEL_PC4;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  cond = br_eq_i;
          F3_BNE:  cond = !br_eq_i;
          F3_BLT:  cond = br_lt_i;
          F3_BGE:  cond = !br_lt_i;
          F3_BLTU: cond = br_ltu_i;
          F3_BGEU: cond = !br_ltu_i;
          default: illegal_o = 1'b1;  // 010 / 011 are reserved
        endcase
        taken_o  = cond;
        pc_sel_o = cond ? PC_SEL_BRANCH : PC_SEL_PC4;
      end
      OP_JAL: begin
        taken_o  = 1'b1;
        pc_sel_o = PC_SEL_JAL;
      end
      OP_JALR: begin
        taken_o  = 1'b1;
        pc_sel_o = PC_SEL_JALR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - request/response branch and jump resolver
// Purpose : captures a branch/jump request, evaluates it one cycle later and
//           holds the registered result until the consumer accepts it.
//           Optional feature macro: BRANCH_STATS_EN adds branch/taken counters.
// Ports   : clk_i, rst_n_i (async active-low)
//           req_valid_i/req_ready_o, opcode_i, funct3_i, pc_i, rs1_i,
//           b_imm_i, j_imm_i, i_imm_i, br_eq_i, br_lt_i, br_ltu_i
//           rsp_valid_o/rsp_ready_i, pc_sel_o, taken_o, target_o,
//           misalign_o, illegal_o
//           br_count_o, taken_count_o (BRANCH_STATS_EN only)
module branch_resolve
  import branch_resolve_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] b_imm_i,
  input  logic [31:0] j_imm_i,
  input  logic [31:0] i_imm_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        br_ltu_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  pc_sel_o,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        misalign_o,
`ifdef BRANCH_STATS_EN
  output logic [31:0] br_count_o,
  output logic [31:0] taken_count_o,
`endif
  output logic        illegal_o
);

  state_e state_q, state_d;
  logic   capture_en, eval_en, rsp_hs;

  // Request captured at the accept edge; nothing downstream sees live inputs.
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q, rs1_q, b_imm_q, j_imm_q, i_imm_q;
  logic        br_eq_q, br_lt_q, br_ltu_q;

  logic        taken_q, misalign_q, illegal_q;
  pc_sel_e     pc_sel_q;
  logic [31:0] target_q;

  logic        dec_taken, dec_illegal;
  pc_sel_e     dec_pc_sel;
  logic [31:0] pc_plus4, br_tgt, jal_tgt, jalr_sum, target_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    capture_en  = 1'b0;
    eval_en     = 1'b0;
    rsp_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          capture_en = 1'b1;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        eval_en = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rsp_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      opcode_q <= '0;
      funct3_q <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      b_imm_q  <= '0;
      j_imm_q  <= '0;
      i_imm_q  <= '0;
      br_eq_q  <= 1'b0;
      br_lt_q  <= 1'b0;
      br_ltu_q <= 1'b0;
    end else if (capture_en) begin
      opcode_q <= opcode_i;
      funct3_q <= funct3_i;
      pc_q     <= pc_i;
      rs1_q    <= rs1_i;
      b_imm_q  <= b_imm_i;
      j_imm_q  <= j_imm_i;
      i_imm_q  <= i_imm_i;
      br_eq_q  <= br_eq_i;
      br_lt_q  <= br_lt_i;
      br_ltu_q <= br_ltu_i;
    end
  end

  branch_decide u_decide (
    .opcode_i  (opcode_q),
    .funct3_i  (funct3_q),
    .br_eq_i   (br_eq_q),
    .br_lt_i   (br_lt_q),
    .br_ltu_i  (br_ltu_q),
    .taken_o   (dec_taken),
    .pc_sel_o  (dec_pc_sel),
    .illegal_o (dec_illegal)
  );

  // All sums are 32-bit and wrap.
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_q + b_imm_q;
  assign jal_tgt  = pc_q + j_imm_q;
  assign jalr_sum = rs1_q + i_imm_q;

  always_comb begin
    target_d = pc_plus4;
    case (dec_pc_sel)
      PC_SEL_JALR:   target_d = {jalr_sum[31:1], 1'b0};
      PC_SEL_BRANCH: target_d = br_tgt;
      PC_SEL_JAL:    target_d = jal_tgt;
      default:       target_d = pc_plus4;
    endcase
  end

  // Result registers load only in EVAL, so they stay frozen through RESP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      pc_sel_q   <= PC_SEL_PC4;
      target_q   <= '0;
    end else if (eval_en) begin
      taken_q    <= dec_taken;
      misalign_q <= dec_taken & target_d[1];
      illegal_q  <= dec_illegal;
      pc_sel_q   <= dec_pc_sel;
      target_q   <= target_d;
    end
  end

  assign taken_o    = taken_q;
  assign misalign_o = misalign_q;
  assign illegal_o  = illegal_q;
  assign pc_sel_o   = pc_sel_q;
  assign target_o   = target_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d, taken_count_q, taken_count_d;
  logic        hs_branch;

  // opcode_q and taken_q are still held during RESP, so the handshake can use them.
  assign hs_branch = rsp_hs && (opcode_q == OP_BRANCH);

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (hs_branch && (br_count_q != 32'hFFFF_FFFF))
      br_count_d = br_count_q + 32'd1;
    if (hs_branch && taken_q && (taken_count_q != 32'hFFFF_FFFF))
      taken_count_d = taken_count_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count_o    = br_count_q;
  assign taken_count_o = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1, b_imm, j_imm, i_imm;
  logic        br_eq, br_lt, br_ltu;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  pc_sel;
  logic        taken, misalign, illegal;
  logic [31:0] target;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .pc_i        (pc),
    .rs1_i       (rs1),
    .b_imm_i     (b_imm),
    .j_imm_i     (j_imm),
    .i_imm_i     (i_imm),
    .br_eq_i     (br_eq),
    .br_lt_i     (br_lt),
    .br_ltu_i    (br_ltu),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .pc_sel_o    (pc_sel),
    .taken_o     (taken),
    .target_o    (target),
    .misalign_o  (misalign),
`ifdef BRANCH_STATS_EN
    .br_count_o    (br_count),
    .taken_count_o (taken_count),
`endif
    .illegal_o   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge after the EVAL edge (RESP).
  task automatic run_req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] bi, input logic [31:0] ji,
                         input logic [31:0] ii, input logic eq, input logic lt, input logic ltu);
    opcode = op; funct3 = f3; pc = p; rs1 = r1;
    b_imm = bi; j_imm = ji; i_imm = ii;
    br_eq = eq; br_lt = lt; br_ltu = ltu;
    req_valid = 1'b1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid_eval", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_eval", {31'd0, req_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic expect_rsp(input string tag, input logic tk, input logic [1:0] sel,
                            input logic [31:0] tgt, input logic mis, input logic ill);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".taken"},     {31'd0, taken},     {31'd0, tk});
    check({tag, ".pc_sel"},    {30'd0, pc_sel},    {30'd0, sel});
    check({tag, ".target"},    target,             tgt);
    check({tag, ".misalign"},  {31'd0, misalign},  {31'd0, mis});
    check({tag, ".illegal"},   {31'd0, illegal},   {31'd0, ill});
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".idle_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".idle_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; funct3 = '0; pc = '0; rs1 = '0;
    b_imm = '0; j_imm = '0; i_imm = '0;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.taken",     {31'd0, taken},     32'd0);
    check("rst.misalign",  {31'd0, misalign},  32'd0);
    check("rst.illegal",   {31'd0, illegal},   32'd0);
    check("rst.pc_sel",    {30'd0, pc_sel},    32'd0);
    check("rst.target",    target,             32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.req_ready_after", {31'd0, req_ready}, 32'd1);
`ifdef BRANCH_STATS_EN
    check("rst.br_count",    br_count,    32'd0);
    check("rst.taken_count", taken_count, 32'd0);
`endif

    // BEQ taken
    run_req(7'b1100011, 3'b000, 32'h100, 32'h0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_rsp("beq_taken", 1'b1, 2'b10, 32'h120, 1'b0, 1'b0);
    // BGEU with LTU=1 -> not taken
    run_req(7'b1100011, 3'b111, 32'h200, 32'h0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    expect_rsp("bgeu_nt", 1'b0, 2'b00, 32'h204, 1'b0, 1'b0);
    // BLT taken, negative offset
    run_req(7'b1100011, 3'b100, 32'h300, 32'h0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_rsp("blt_back", 1'b1, 2'b10, 32'h2F0, 1'b0, 1'b0);
    // BNE with EQ=0 -> taken, target bit1 set -> misalign
    run_req(7'b1100011, 3'b001, 32'h500, 32'h0, 32'h6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_rsp("bne_mis", 1'b1, 2'b10, 32'h506, 1'b1, 1'b0);
    // BGE with LT=1 -> not taken; PC+4 never counted as misaligned
    run_req(7'b1100011, 3'b101, 32'h602, 32'h0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_rsp("bge_nt", 1'b0, 2'b00, 32'h606, 1'b0, 1'b0);
    // JALR clears bit 0
    run_req(7'b1100111, 3'b000, 32'h700, 32'h1001, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    expect_rsp("jalr", 1'b1, 2'b01, 32'h1004, 1'b0, 1'b0);
    // JALR misaligned
    run_req(7'b1100111, 3'b000, 32'h700, 32'h1002, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_rsp("jalr_mis", 1'b1, 2'b01, 32'h1002, 1'b1, 1'b0);
    // Reserved branch FUNCT3
    run_req(7'b1100011, 3'b010, 32'h800, 32'h0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    expect_rsp("illegal010", 1'b0, 2'b00, 32'h804, 1'b0, 1'b1);
    run_req(7'b1100011, 3'b011, 32'h900, 32'h0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    expect_rsp("illegal011", 1'b0, 2'b00, 32'h904, 1'b0, 1'b1);
    // JAL wraps
    run_req(7'b1101111, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_rsp("jal_wrap", 1'b1, 2'b11, 32'h4, 1'b0, 1'b0);
    // Non-branch opcode
    run_req(7'b0110011, 3'b000, 32'hA00, 32'h0, 32'h40, 32'h80, 32'h0, 1'b1, 1'b1, 1'b1);
    expect_rsp("other_op", 1'b0, 2'b00, 32'hA04, 1'b0, 1'b0);

    // Back-pressure: result frozen while inputs churn
    run_req(7'b1100011, 3'b000, 32'h400, 32'h0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      opcode = 7'b1101111; pc = 32'h1000 * (i + 1); j_imm = 32'h44; br_eq = 1'b0;
      @(posedge clk); @(negedge clk);
      check("hold.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold.req_ready", {31'd0, req_ready}, 32'd0);
      check("hold.target",    target,             32'h410);
      check("hold.pc_sel",    {30'd0, pc_sel},    32'd2);
    end
    req_valid = 1'b0;
    expect_rsp("hold_done", 1'b1, 2'b10, 32'h410, 1'b0, 1'b0);

    // Reset while in RESP discards the result
    run_req(7'b1101111, 3'b000, 32'hB00, 32'h0, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rstresp.pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstresp.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstresp.taken",     {31'd0, taken},     32'd0);
    check("rstresp.target",    target,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstresp.req_ready", {31'd0, req_ready}, 32'd1);
    check("rstresp.no_rsp",    {31'd0, rsp_valid}, 32'd0);

`ifdef BRANCH_STATS_EN
    check("stats.br0",    br_count,    32'd0);
    check("stats.taken0", taken_count, 32'd0);
    run_req(7'b1100011, 3'b000, 32'h100, 32'h0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_rsp("st_beq", 1'b1, 2'b10, 32'h120, 1'b0, 1'b0);
    run_req(7'b1100011, 3'b001, 32'h100, 32'h0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_rsp("st_bne", 1'b0, 2'b00, 32'h104, 1'b0, 1'b0);
    run_req(7'b1100011, 3'b110, 32'h100, 32'h0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    expect_rsp("st_bltu", 1'b1, 2'b10, 32'h120, 1'b0, 1'b0);
    run_req(7'b1101111, 3'b000, 32'h100, 32'h0, 32'h0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_rsp("st_jal", 1'b1, 2'b11, 32'h108, 1'b0, 1'b0);
    check("stats.br_count",    br_count,    32'd3);
    check("stats.taken_count", taken_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
